// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with next-PC selection and a circular
// return-address stack (RAS).
//
// Next-PC sources (PC_SEL): 0 = sequential PC_NEXT, 1 = PC_TARGET,
// 2 = RAS top (falls through to PC_NEXT when the stack is empty),
// 3 = TRAP_VEC.
//
// Optional feature, enabled by defining the macro PC_MISALIGN_EN:
// a selected next PC whose bits [1:0] are non-zero is replaced by TRAP_VEC
// and PC_MISALIGN pulses high for one cycle. TRAP_VEC itself is never
// checked. With the macro undefined the selected value is loaded unchanged
// and PC_MISALIGN is tied low.
module pc_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0000),
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           PC_RST,
  input  logic                           PC_WRITE,
  input  logic [1:0]                     PC_SEL,
  input  logic [WIDTH-1:0]               PC_TARGET,
  input  logic [WIDTH-1:0]               TRAP_VEC,
  input  logic                           RAS_PUSH,
  input  logic                           RAS_POP,
  output logic [WIDTH-1:0]               PC,
  output logic [WIDTH-1:0]               PC_NEXT,
  output logic [WIDTH-1:0]               RAS_TOP,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RAS_COUNT,
  output logic                           RAS_EMPTY,
  output logic                           RAS_FULL,
  output logic                           PC_MISALIGN
);

  // Pointer indexes the stack storage; the count needs one extra state to
  // represent "full" separately from "empty".
  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // PC selector encodings
  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_TARGET = 2'd1;
  localparam logic [1:0] SEL_RAS    = 2'd2;
  localparam logic [1:0] SEL_TRAP   = 2'd3;

  // Architectural state
  logic [WIDTH-1:0] pc_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             misalign_q;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  // Next-state and control signals
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] top_value;
  logic             ras_empty;
  logic             ras_full;
  logic             push_en;
  logic             pop_en;
  logic [WIDTH-1:0] sel_pc;
  logic [WIDTH-1:0] load_pc;
  logic             misaligned;
  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] cnt_next;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // Sequential successor and stack status, derived from registered state only
  always_comb begin
    pc_seq    = pc_q + WIDTH'(INC);
    ras_empty = (cnt_q == '0);
    ras_full  = (cnt_q == CNT_MAX);
    top_value = ras_empty ? '0 : ras_mem[ptr_q];
  end

  // Push/pop only count when the PC is actually advancing
  always_comb begin
    push_en = PC_WRITE & RAS_PUSH;
    pop_en  = PC_WRITE & RAS_POP;
  end

  // Next-PC mux; the RAS value used is the pre-update top of stack
  always_comb begin
    sel_pc = pc_seq;
    case (PC_SEL)
      SEL_SEQ:    sel_pc = pc_seq;
      SEL_TARGET: sel_pc = PC_TARGET;
      SEL_RAS:    sel_pc = ras_empty ? pc_seq : top_value;
      SEL_TRAP:   sel_pc = TRAP_VEC;
      default:    sel_pc = pc_seq;
    endcase
  end

`ifdef PC_MISALIGN_EN
  // Redirect misaligned fetch targets to the trap vector; the trap vector
  // itself is trusted and never redirected
  always_comb begin
    misaligned = (PC_SEL != SEL_TRAP) && (sel_pc[1:0] != 2'b00);
    load_pc    = misaligned ? TRAP_VEC : sel_pc;
  end
`else
  // Misalignment checking disabled: load the selected value unchanged
  always_comb begin
    misaligned = 1'b0;
    load_pc    = sel_pc;
  end
`endif

  // Stack pointer/count update and storage write decision
  always_comb begin
    ptr_next = ptr_q;
    cnt_next = cnt_q;
    wr_en    = 1'b0;
    wr_idx   = ptr_q;
    if (push_en && pop_en && !ras_empty) begin
      // Return immediately followed by a call: replace the top entry
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (push_en) begin
      // Plain push; when full the oldest entry is silently overwritten
      wr_en    = 1'b1;
      wr_idx   = ptr_q + PTR_ONE;
      ptr_next = ptr_q + PTR_ONE;
      cnt_next = ras_full ? cnt_q : cnt_q + CNT_ONE;
    end else if (pop_en && !ras_empty) begin
      // Pop: underflow leaves pointer and count untouched
      ptr_next = ptr_q - PTR_ONE;
      cnt_next = cnt_q - CNT_ONE;
    end
  end

  // PC, pointer, count and misalignment flag registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (PC_RST) begin
      pc_q       <= RESET_VEC;
      ptr_q      <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= PC_WRITE & misaligned;
      if (PC_WRITE) begin
        pc_q  <= load_pc;
        ptr_q <= ptr_next;
        cnt_q <= cnt_next;
      end
    end
  end

  // Stack storage; contents are not reset, only the pointer and count are
  always_ff @(posedge CLK) begin
    if (wr_en && !PC_RST) begin
      ras_mem[wr_idx] <= pc_seq;
    end
  end

  // Output drive
  always_comb begin
    PC          = pc_q;
    PC_NEXT     = pc_seq;
    RAS_TOP     = top_value;
    RAS_COUNT   = cnt_q;
    RAS_EMPTY   = ras_empty;
    RAS_FULL    = ras_full;
    PC_MISALIGN = misalign_q;
  end

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: scoreboard bench for pc_ras (WIDTH=32, RESET_VEC=0, INC=4,
// RAS_DEPTH=4). Expectations come from a queue-based reference stack.
// Honours PC_MISALIGN_EN if the design is built with it.
module tb_pc_ras;

  logic        CLK;
  logic        PC_RST;
  logic        PC_WRITE;
  logic [1:0]  PC_SEL;
  logic [31:0] PC_TARGET;
  logic [31:0] TRAP_VEC;
  logic        RAS_PUSH;
  logic        RAS_POP;
  logic [31:0] PC;
  logic [31:0] PC_NEXT;
  logic [31:0] RAS_TOP;
  logic [2:0]  RAS_COUNT;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        PC_MISALIGN;

  pc_ras #(
    .WIDTH     (32),
    .RESET_VEC (32'h0000_0000),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut (
    .CLK         (CLK),
    .PC_RST      (PC_RST),
    .PC_WRITE    (PC_WRITE),
    .PC_SEL      (PC_SEL),
    .PC_TARGET   (PC_TARGET),
    .TRAP_VEC    (TRAP_VEC),
    .RAS_PUSH    (RAS_PUSH),
    .RAS_POP     (RAS_POP),
    .PC          (PC),
    .PC_NEXT     (PC_NEXT),
    .RAS_TOP     (RAS_TOP),
    .RAS_COUNT   (RAS_COUNT),
    .RAS_EMPTY   (RAS_EMPTY),
    .RAS_FULL    (RAS_FULL),
    .PC_MISALIGN (PC_MISALIGN)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] top;
    logic [31:0] count;
    logic        empty;
    logic        full;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_stack[$];
  logic [31:0] m_pc;
  logic        m_mis;
  int          compared;
  int          mismatched;

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs
  task automatic modelStep(input logic rst, input logic wr, input logic [1:0] sel,
                           input logic [31:0] tgt, input logic [31:0] trap,
                           input logic push, input logic pop);
    logic [31:0] nxt;
    logic [31:0] sel_v;
    logic        mis;
    if (rst) begin
      m_pc  = 32'h0;
      m_mis = 1'b0;
      m_stack.delete();
    end else if (wr) begin
      nxt = m_pc + 32'd4;
      case (sel)
        2'd0:    sel_v = nxt;
        2'd1:    sel_v = tgt;
        2'd2:    sel_v = (m_stack.size() == 0) ? nxt : m_stack[m_stack.size()-1];
        default: sel_v = trap;
      endcase
      mis = 1'b0;
`ifdef PC_MISALIGN_EN
      if (sel != 2'd3 && sel_v[1:0] != 2'b00) begin
        sel_v = trap;
        mis   = 1'b1;
      end
`endif
      if (push && pop && m_stack.size() > 0) begin
        m_stack[m_stack.size()-1] = nxt;
      end else if (push) begin
        m_stack.push_back(nxt);
        if (m_stack.size() > 4) void'(m_stack.pop_front());
      end else if (pop && m_stack.size() > 0) begin
        void'(m_stack.pop_back());
      end
      m_pc  = sel_v;
      m_mis = mis;
    end else begin
      m_mis = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then check
  // the DUT against the oldest queued prediction after the edge
  task automatic applyStimulus(input string tag, input logic rst, input logic wr,
                               input logic [1:0] sel, input logic [31:0] tgt,
                               input logic [31:0] trap, input logic push,
                               input logic pop);
    exp_t e;
    exp_t g;
    @(negedge CLK);
    PC_RST    = rst;
    PC_WRITE  = wr;
    PC_SEL    = sel;
    PC_TARGET = tgt;
    TRAP_VEC  = trap;
    RAS_PUSH  = push;
    RAS_POP   = pop;
    modelStep(rst, wr, sel, tgt, trap, push, pop);
    e.pc      = m_pc;
    e.pc_next = m_pc + 32'd4;
    e.top     = (m_stack.size() == 0) ? 32'h0 : m_stack[m_stack.size()-1];
    e.count   = 32'(m_stack.size());
    e.empty   = (m_stack.size() == 0);
    e.full    = (m_stack.size() == 4);
    e.mis     = m_mis;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      checkOutput({tag, ".pc"}, PC, g.pc);
      checkOutput({tag, ".pc_next"}, PC_NEXT, g.pc_next);
      checkOutput({tag, ".top"}, RAS_TOP, g.top);
      checkOutput({tag, ".count"}, {29'd0, RAS_COUNT}, g.count);
      checkOutput({tag, ".empty"}, {31'd0, RAS_EMPTY}, {31'd0, g.empty});
      checkOutput({tag, ".full"}, {31'd0, RAS_FULL}, {31'd0, g.full});
      checkOutput({tag, ".misalign"}, {31'd0, PC_MISALIGN}, {31'd0, g.mis});
    end
  endtask

  // Directed scenario sequence followed by the summary
  initial begin
    compared   = 0;
    mismatched = 0;
    m_pc       = 32'h0;
    m_mis      = 1'b0;
    PC_RST     = 1'b1;
    PC_WRITE   = 1'b0;
    PC_SEL     = 2'd0;
    PC_TARGET  = 32'h0;
    TRAP_VEC   = 32'h80;
    RAS_PUSH   = 1'b0;
    RAS_POP    = 1'b0;

    $display("[TB] reset and sequential run");
    applyStimulus("rst", 1, 0, 0, 32'h0, 32'h80, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("seq", 0, 1, 0, 32'h0, 32'h80, 0, 0);
    applyStimulus("seq_push", 0, 1, 0, 32'h0, 32'h80, 1, 0);
    applyStimulus("rst_mid", 1, 1, 1, 32'h500, 32'h80, 1, 0);

    $display("[TB] stall");
    applyStimulus("goto20", 0, 1, 1, 32'h20, 32'h80, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("stall", 0, 0, 1, 32'h500, 32'h80, 1, 0);

    $display("[TB] call and return");
    applyStimulus("goto100", 0, 1, 1, 32'h100, 32'h80, 0, 0);
    applyStimulus("call", 0, 1, 1, 32'h400, 32'h80, 1, 0);
    applyStimulus("ret", 0, 1, 2, 32'h0, 32'h80, 0, 1);

    $display("[TB] overflow and underflow");
    for (int i = 0; i < 5; i++) begin
      applyStimulus("ovf_jmp", 0, 1, 1, 32'(i * 16), 32'h80, 0, 0);
      applyStimulus("ovf_push", 0, 1, 1, 32'h800, 32'h80, 1, 0);
    end
    for (int i = 0; i < 5; i++) applyStimulus("unf_pop", 0, 1, 2, 32'h0, 32'h80, 0, 1);

    $display("[TB] simultaneous push and pop");
    applyStimulus("pp_rst", 1, 0, 0, 32'h0, 32'h80, 0, 0);
    applyStimulus("pp_jmp", 0, 1, 1, 32'h100, 32'h80, 0, 0);
    applyStimulus("pp_call1", 0, 1, 1, 32'h200, 32'h80, 1, 0);
    applyStimulus("pp_call2", 0, 1, 1, 32'h300, 32'h80, 1, 0);
    applyStimulus("pp_both", 0, 1, 0, 32'h0, 32'h80, 1, 1);
    applyStimulus("pp_empty_rst", 1, 0, 0, 32'h0, 32'h80, 0, 0);
    applyStimulus("pp_empty", 0, 1, 0, 32'h0, 32'h80, 1, 1);

    $display("[TB] misalignment");
    applyStimulus("mis_jmp", 0, 1, 1, 32'h402, 32'h80, 0, 0);
    applyStimulus("mis_hold", 0, 0, 0, 32'h0, 32'h80, 0, 0);
    applyStimulus("mis_trap", 0, 1, 3, 32'h0, 32'h82, 0, 0);

    $display("[TB] wrap-around");
    applyStimulus("wrap_jmp", 0, 1, 1, 32'hFFFF_FFFC, 32'h80, 0, 0);
    applyStimulus("wrap_seq", 0, 1, 0, 32'h0, 32'h80, 0, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program-counter unit for the RISC-V MCU fetch stage: holds the current PC, selects the next PC (sequential, external target, return-address prediction, trap vector) and maintains a circular return-address stack (RAS) of configurable depth. It replaces the plain loadable PC register: next-PC muxing and call/return tracking move inside the block. The fetch memory reads `PC`; the control unit drives `PC_WRITE`, `PC_SEL` and the push/pop strobes.

## Interface

Parameters:
- `WIDTH`, 32, PC and address width in bits (≥ 8).
- `RESET_VEC`, 32'h0000_0000, PC value loaded on reset.
- `INC`, 4, sequential increment in bytes.
- `RAS_DEPTH`, 4, number of RAS entries (power of two, 2–16).

Ports:
- `CLK` in 1: clock, all state updates on rising edge.
- `PC_RST` in 1: synchronous, active-high reset.
- `PC_WRITE` in 1: advance enable. When 0, the PC and the RAS hold.
- `PC_SEL` in 2: next-PC source. 0 = `PC_NEXT`, 1 = `PC_TARGET`, 2 = RAS top, 3 = `TRAP_VEC`.
- `PC_TARGET` in WIDTH: branch/jump target from the datapath.
- `TRAP_VEC` in WIDTH: trap handler address (mtvec).
- `RAS_PUSH` in 1: call; push `PC_NEXT`.
- `RAS_POP` in 1: return; pop the top entry.
- `PC` out WIDTH: current PC, registered.
- `PC_NEXT` out WIDTH: `PC + INC`, combinational, modulo 2^WIDTH.
- `RAS_TOP` out WIDTH: top entry, or 0 when empty.
- `RAS_COUNT` out $clog2(RAS_DEPTH+1): number of valid entries.
- `RAS_EMPTY` out 1: `RAS_COUNT == 0`.
- `RAS_FULL` out 1: `RAS_COUNT == RAS_DEPTH`.
- `PC_MISALIGN` out 1: registered misalignment flag (see Configuration).

## Operation

- **Reset.** `PC_RST` = 1 at a rising edge sets `PC` = RESET_VEC, `RAS_COUNT` = 0, top pointer = 0 and `PC_MISALIGN` = 0.
  - RAS entry contents are not cleared and are don't-care.
  - Reset has priority over every other input, including mid-push or pop.
- **PC update.** With `PC_WRITE` = 1, `PC` loads the source chosen by `PC_SEL`.
  - When `PC_SEL` = 2 and the RAS is empty, the selected value is `PC_NEXT` (fall-through).
  - The selected value is computed before this cycle's push or pop takes effect.
- **Strobe qualification.** `RAS_PUSH` and `RAS_POP` take effect only when `PC_WRITE` = 1.
- **Push.** Writes `PC_NEXT` (old PC + INC) at top pointer + 1 (mod RAS_DEPTH), then advances the pointer.
  - `RAS_COUNT` increments and saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry (circular). Count stays at RAS_DEPTH.
- **Pop.** Decrements the pointer (mod RAS_DEPTH) and `RAS_COUNT`.
  - Pop when empty does nothing. The pointer and count are unchanged.
- **Push and pop in the same cycle.** Overwrites the top entry with `PC_NEXT`. Pointer and count are unchanged.
  - If the RAS is empty, this behaves as a plain push.
- **Wrap-around.** `PC_NEXT` and all PC arithmetic wrap modulo 2^WIDTH. `PC` = 2^WIDTH − INC gives `PC_NEXT` = 0.

## Timing

- `PC` changes only at a rising edge, one cycle after the qualifying `PC_WRITE`. There is no combinational path from inputs to `PC`.
- `PC_NEXT`, `RAS_TOP`, `RAS_COUNT`, `RAS_EMPTY` and `RAS_FULL` are combinational from registered state only, valid in the same cycle.
- A pushed entry is visible on `RAS_TOP` in the cycle after the push edge.
- `PC_MISALIGN` is registered. It is high for exactly the one cycle following the offending edge.
- With `PC_WRITE` = 0 for N cycles, all outputs are stable for N cycles.

## Configuration

- Macro: `PC_MISALIGN_EN`.
- **Defined.** On a qualifying `PC_WRITE` edge where the selected next PC has bits [1:0] ≠ 0:
  - `PC` loads `TRAP_VEC` instead of the selected value.
  - `PC_MISALIGN` is 1 for the next cycle.
  - The push or pop still applies.
  - `TRAP_VEC` itself is never checked.
- **Undefined.** The selected value is loaded unchanged and `PC_MISALIGN` is tied to 0.

## Test plan

- **Reset then sequential run.** Apply reset with RESET_VEC = 0. `PC_WRITE` = 1, `PC_SEL` = 0 for 3 cycles → `PC` = 0, 4, 8, 12. Assert reset mid-run → `PC` = 0 and `RAS_COUNT` = 0 on the next edge.
- **Stall.** `PC` = 0x20 with `PC_WRITE` = 0 for 5 cycles, `PC_SEL` = 1, `RAS_PUSH` = 1 → `PC` stays 0x20 and `RAS_COUNT` stays 0.
- **Call and return.**
  - At `PC` = 0x100, drive `PC_SEL` = 1, `PC_TARGET` = 0x400, `RAS_PUSH` = 1 → `PC` = 0x400, `RAS_TOP` = 0x104, `RAS_COUNT` = 1.
  - Then drive `PC_SEL` = 2, `RAS_POP` = 1 → `PC` = 0x104 and `RAS_EMPTY` = 1.
- **Overflow and underflow (RAS_DEPTH = 4).** Push 5 times from PCs 0x0, 0x10, 0x20, 0x30, 0x40 → `RAS_FULL` = 1 and `RAS_COUNT` = 4. Popping then yields 0x44, 0x34, 0x24, 0x14, then empty. A further pop leaves the count at 0. `PC_SEL` = 2 while empty loads `PC_NEXT`.
- **Simultaneous push and pop.** With the top = 0x204 and count = 2, at `PC` = 0x300 → top becomes 0x304 and the count stays 2.
- **Misalignment (`PC_MISALIGN_EN` defined).** `PC_SEL` = 1, `PC_TARGET` = 0x402, `TRAP_VEC` = 0x80 → `PC` = 0x80 and `PC_MISALIGN` = 1 for one cycle. With the macro undefined → `PC` = 0x402 and `PC_MISALIGN` = 0.
